mp2_mult_arbiter: RTL and testbench
===================================

# mp2_mult_arbiter

Shares the single 18x18 signed hardware multiplier of the MP2 audio decoder between three requesters:
- port 0: dequantise/denormalise buffer
- port 1: subband synthesis matrixing
- port 2: synthesis windowing

The block picks a requester each cycle and registers its operands into the multiplier. It then routes each product back through a pipeline that tags the product with the originating port. A requester can lock the multiplier for an uninterrupted burst, for example a full matrixing dot product.

## Interface
Parameters:
- PIPE_STAGES, 2, cycles from an accepted transfer to Result_Valid_O; legal range 2..4
- OP_WIDTH, 18, operand width; product width is 2*OP_WIDTH

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  synchronous active-low reset; one clock, reset sampled on the rising edge of clock
- Req_I  in  3  per-port request; operands valid while high
- Lock_I  in  3  per-port lock; holds ownership after a transfer
- OpA_I  in  3*OP_WIDTH  packed operand A; port k uses bits [k*18+17:k*18]
- OpB_I  in  3*OP_WIDTH  packed operand B, same packing as OpA_I
- Grant_O  out  3  one-hot or zero; combinational from Req_I and state
- Result_O  out  2*OP_WIDTH  registered product, broadcast to all ports
- Result_Valid_O  out  3  one-hot; marks the owner of Result_O this cycle
- Mult_OP_0_O  out  OP_WIDTH  registered operand A to the multiplier
- Mult_OP_1_O  out  OP_WIDTH  registered operand B to the multiplier
- Mult_Result_I  in  2*OP_WIDTH  combinational signed product of Mult_OP_0_O and Mult_OP_1_O

## Operation
A transfer on port k occurs in any cycle where Req_I[k] and Grant_O[k] are both high. At most one transfer occurs per cycle.

FSM states: ARB_IDLE, ARB_LOCKED.

ARB_IDLE:
- Grant_O is the arbitration winner among the set bits of Req_I. Grant_O is 0 when Req_I is 0.
- A transfer with Lock_I[k]=1 moves the FSM to ARB_LOCKED with owner=k.
- Otherwise the FSM stays in ARB_IDLE.

ARB_LOCKED:
- Grant_O = onehot(owner), regardless of the other ports' Req_I.
- The owner may drop Req_I for any number of cycles without losing ownership.
- When Lock_I[owner]=0 at a clock edge, the FSM returns to ARB_IDLE. If the owner has Req_I high in that same cycle, that transfer still completes on the owner.
- Requests from other ports are held off. They are not dropped; the requester keeps Req_I high until granted.

Datapath on each transfer:
- OpA_I/OpB_I of port k are registered into Mult_OP_0_O/Mult_OP_1_O.
- A valid bit and a 2-bit tag k enter the tag pipeline.
- On cycles with no transfer, Mult_OP_* hold their previous value and a zero valid bit enters the pipeline.

Result path:
- Mult_Result_I is registered through PIPE_STAGES-1 stages to Result_O. There is no rounding and no truncation.
- Result_Valid_O = decode(tag) when the final valid bit is set, otherwise 0.
- Result_O holds its value when Result_Valid_O is 0.

Reset (resetn=0):
- FSM goes to ARB_IDLE; the round-robin pointer goes to port 2, so port 0 has highest priority next.
- All pipeline valid bits are cleared; the pipeline's in-flight products are discarded.
- Outputs reset to: Grant_O=0, Result_O=0, Result_Valid_O=0, Mult_OP_0_O=0, Mult_OP_1_O=0.
- Grant_O is forced to 0 while resetn=0, even though it is combinational.

## Timing
- Transfer in cycle t: Mult_OP_* are valid in t+1, and Result_Valid_O[k] is high in cycle t+PIPE_STAGES.
- Throughput: one product per cycle. Back-to-back transfers from different ports interleave results in issue order.
- A lock asserted on the transfer in cycle t takes effect in cycle t+1. In cycle t itself, arbitration has already granted k.
- A lock release is sampled at the edge ending cycle t. Other ports may be granted from cycle t+1.
- Simultaneous requests are resolved in one cycle; there is no idle bubble between winners.
- Mid-operation reset: products of transfers issued up to PIPE_STAGES-1 cycles earlier never assert Result_Valid_O.

## Configuration
Macro: MP2_MULT_ARB_RR_EN (defined in defines.v).
- Defined: round-robin arbitration in ARB_IDLE. Search starts at the port after the last granted port, and the pointer updates on every transfer.
- Undefined: fixed priority 0 > 1 > 2. The pointer register is not synthesised.
- Lock behaviour is identical in both builds.

## Test plan
1. Reset, then Req_I=3'b001 with OpA=18'h00003 and OpB=18'h3FFFE (-2). Expect Grant_O=001 in the same cycle, and Result_Valid_O=001 with Result_O=36'hFFFFFFFFA exactly 2 cycles later (PIPE_STAGES=2).
2. Req_I=3'b111 held for 6 cycles, no lock, RR_EN defined. Expect grants 001,010,100,001,010,100. With RR_EN undefined, expect 001 on all 6 cycles.
3. Port 1 transfers with Lock_I[1]=1, then drops Req_I for 3 cycles while Req_I[0]=1. Expect Grant_O=010 throughout those 3 cycles. Then Lock_I[1] falls; expect Grant_O=001 on the next cycle.
4. Alternating transfers from ports 2 and 0 on consecutive cycles. Expect Result_Valid_O to sequence 100,001 with the matching products, one per cycle, no gaps.
5. Transfer in cycle t, resetn=0 in cycle t+1. Expect Result_Valid_O to stay 0 through t+4, and all outputs 0 in the cycle after reset.
6. PIPE_STAGES=4, single transfer of 18'h1FFFF × 18'h1FFFF. Expect Result_O=36'h3FFFC0001 with its valid asserted exactly 4 cycles after the transfer.

Source files
------------

// File: rtl/mp2_mult_arbiter_if.sv
// Requester/multiplier bus for the MP2 shared 18x18 multiplier arbiter.
// The slave side is the arbiter. The master side is the requesters plus the external multiplier.
interface mp2_mult_arbiter_if #(
    parameter int OP_WIDTH = 18
);
    logic [2:0]              Req_I;
    logic [2:0]              Lock_I;
    logic [3*OP_WIDTH-1:0]   OpA_I;
    logic [3*OP_WIDTH-1:0]   OpB_I;
    logic [2:0]              Grant_O;
    logic [2*OP_WIDTH-1:0]   Result_O;
    logic [2:0]              Result_Valid_O;
    logic [OP_WIDTH-1:0]     Mult_OP_0_O;
    logic [OP_WIDTH-1:0]     Mult_OP_1_O;
    logic [2*OP_WIDTH-1:0]   Mult_Result_I;

    modport slave (
        input  Req_I, Lock_I, OpA_I, OpB_I, Mult_Result_I,
        output Grant_O, Result_O, Result_Valid_O, Mult_OP_0_O, Mult_OP_1_O
    );

    modport master (
        output Req_I, Lock_I, OpA_I, OpB_I, Mult_Result_I,
        input  Grant_O, Result_O, Result_Valid_O, Mult_OP_0_O, Mult_OP_1_O
    );
endinterface

// File: rtl/mp2_mult_arbiter.sv
// Three-port arbiter for the shared MP2 multiplier, with a lockable burst mode and a tagged result pipeline.
// Define MP2_MULT_ARB_RR_EN to get round-robin arbitration; without it the arbiter uses fixed priority 0 > 1 > 2.
module mp2_mult_arbiter #(
    parameter int PIPE_STAGES = 2,
    parameter int OP_WIDTH    = 18
) (
    input  logic                 clock,
    input  logic                 resetn,
    mp2_mult_arbiter_if.slave    bus
);
    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

    arb_state_e                     state_q, state_d;
    logic [1:0]                     owner_q, owner_d;
    logic [2:0]                     grant;
    logic [2:0]                     winner;
    logic                           xfer;
    logic [1:0]                     xfer_port;
    logic signed [OP_WIDTH-1:0]     op0_q, op1_q;
    logic [PIPE_STAGES-1:0]         vld_q;
    logic [1:0]                     tag_q  [PIPE_STAGES];
    logic signed [2*OP_WIDTH-1:0]   prod_q [PIPE_STAGES-1];

    function automatic logic [2:0] onehot(input logic [1:0] k);
        return 3'b001 << k;
    endfunction

    function automatic logic [1:0] encode(input logic [2:0] g);
        return g[2] ? 2'd2 : (g[1] ? 2'd1 : 2'd0);
    endfunction

`ifdef MP2_MULT_ARB_RR_EN
    logic [1:0] ptr_q;

    // The loop runs from the farthest port to the nearest, so the nearest requester after 'last' is written last and wins.
    function automatic logic [2:0] pick_rr(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] idx;
        pick_rr = 3'b000;
        for (int i = 3; i >= 1; i--) begin
            idx = 2'((int'(last) + i) % 3);
            if (req[idx]) pick_rr = onehot(idx);
        end
    endfunction

    always_ff @(posedge clock) begin
        if (!resetn)   ptr_q <= 2'd2;
        else if (xfer) ptr_q <= xfer_port;
    end

    assign winner = pick_rr(bus.Req_I, ptr_q);
`else
    function automatic logic [2:0] pick_fixed(input logic [2:0] req);
        if (req[0])      return 3'b001;
        else if (req[1]) return 3'b010;
        else if (req[2]) return 3'b100;
        return 3'b000;
    endfunction

    assign winner = pick_fixed(bus.Req_I);
`endif

    // FSM state register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= ARB_IDLE;
            owner_q <= 2'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ARB_IDLE: begin
                if (xfer && bus.Lock_I[xfer_port]) begin
                    state_d = ARB_LOCKED;
                    owner_d = xfer_port;
                end
            end
            ARB_LOCKED: begin
                if (!bus.Lock_I[owner_q]) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // FSM outputs: the grant is combinational and is held at zero while resetn is low.
    always_comb begin
        grant = 3'b000;
        if (resetn) begin
            if (state_q == ARB_LOCKED) grant = onehot(owner_q);
            else                       grant = winner;
        end
    end

    assign xfer      = |(bus.Req_I & grant);
    assign xfer_port = encode(grant);

    // Operand register (issue stage)
    always_ff @(posedge clock) begin
        if (!resetn) begin
            op0_q <= '0;
            op1_q <= '0;
        end else if (xfer) begin
            op0_q <= bus.OpA_I[int'(xfer_port)*OP_WIDTH +: OP_WIDTH];
            op1_q <= bus.OpB_I[int'(xfer_port)*OP_WIDTH +: OP_WIDTH];
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) vld_q <= '0;
        else         vld_q <= {vld_q[PIPE_STAGES-2:0], xfer};
    end

    always_ff @(posedge clock) begin
        tag_q[0] <= xfer_port;
        for (int i = 1; i < PIPE_STAGES; i++) tag_q[i] <= tag_q[i-1];
    end

    // Product stages: each stage loads only under its valid bit, so the last stage holds between results.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            prod_q[PIPE_STAGES-2] <= '0;
        end else begin
            if (vld_q[0]) prod_q[0] <= bus.Mult_Result_I;
            for (int j = 1; j < PIPE_STAGES-1; j++) begin
                if (vld_q[j]) prod_q[j] <= prod_q[j-1];
            end
        end
    end

    assign bus.Grant_O        = grant;
    assign bus.Mult_OP_0_O    = op0_q;
    assign bus.Mult_OP_1_O    = op1_q;
    assign bus.Result_O       = prod_q[PIPE_STAGES-2];
    assign bus.Result_Valid_O = vld_q[PIPE_STAGES-1] ? onehot(tag_q[PIPE_STAGES-1]) : 3'b000;
endmodule

// File: tb/tb_mp2_mult_arbiter.sv
// Randomised bench for mp2_mult_arbiter. It drives a PIPE_STAGES=2 and a PIPE_STAGES=4 instance in lockstep
// and checks both against a transaction-level model of arbitration, locking and result latency.
module tb_mp2_mult_arbiter;
    localparam int W = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic [2:0]    req, lock;
    logic [3*W-1:0] opa, opb;

    mp2_mult_arbiter_if #(.OP_WIDTH(W)) bus2 ();
    mp2_mult_arbiter_if #(.OP_WIDTH(W)) bus4 ();

    assign bus2.Req_I  = req;
    assign bus2.Lock_I = lock;
    assign bus2.OpA_I  = opa;
    assign bus2.OpB_I  = opb;
    assign bus4.Req_I  = req;
    assign bus4.Lock_I = lock;
    assign bus4.OpA_I  = opa;
    assign bus4.OpB_I  = opb;

    // External combinational multipliers
    logic signed [2*W-1:0] m2a, m2b, m4a, m4b;
    assign m2a = 36'($signed(bus2.Mult_OP_0_O));
    assign m2b = 36'($signed(bus2.Mult_OP_1_O));
    assign m4a = 36'($signed(bus4.Mult_OP_0_O));
    assign m4b = 36'($signed(bus4.Mult_OP_1_O));
    assign bus2.Mult_Result_I = m2a * m2b;
    assign bus4.Mult_Result_I = m4a * m4b;

    mp2_mult_arbiter #(.PIPE_STAGES(2), .OP_WIDTH(W)) u_dut2 (.clock(clk), .resetn(rstn), .bus(bus2));
    mp2_mult_arbiter #(.PIPE_STAGES(4), .OP_WIDTH(W)) u_dut4 (.clock(clk), .resetn(rstn), .bus(bus4));

    logic [2:0]   gnt [2];
    logic [2:0]   rv  [2];
    logic [35:0]  ro  [2];
    logic [17:0]  o0  [2];
    logic [17:0]  o1  [2];
    assign gnt[0] = bus2.Grant_O;        assign gnt[1] = bus4.Grant_O;
    assign rv[0]  = bus2.Result_Valid_O; assign rv[1]  = bus4.Result_Valid_O;
    assign ro[0]  = bus2.Result_O;       assign ro[1]  = bus4.Result_O;
    assign o0[0]  = bus2.Mult_OP_0_O;    assign o0[1]  = bus4.Mult_OP_0_O;
    assign o1[0]  = bus2.Mult_OP_1_O;    assign o1[1]  = bus4.Mult_OP_1_O;

    typedef struct {
        int          due;
        logic [2:0]  vld;
        logic [35:0] prod;
    } res_t;

    res_t        q [2][$];
    logic [35:0] held [2];
    logic [17:0] eop0, eop1;
    logic        m_locked;
    int          m_owner, m_last;
    int          cyc;
    logic        known;
    int          n_chk = 0;
    int          n_bad = 0;
    int          lat [2] = '{2, 4};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [2:0] model_grant();
        if (!rstn)    return 3'b000;
        if (m_locked) return 3'(1 << m_owner);
`ifdef MP2_MULT_ARB_RR_EN
        for (int d = 1; d <= 3; d++) begin
            int k;
            k = (m_last + d) % 3;
            if (req[k]) return 3'(1 << k);
        end
`else
        for (int k = 0; k < 3; k++) if (req[k]) return 3'(1 << k);
`endif
        return 3'b000;
    endfunction

    // One clock cycle: check the outputs, then advance the model across the edge.
    task automatic run_cycle();
        logic [2:0] g_exp, ev;
        logic signed [17:0] a, b;
        logic signed [35:0] p;
        int k;
        logic was;
        #1;
        g_exp = model_grant();
        check_val("grant_p2", 64'(gnt[0]), 64'(g_exp));
        check_val("grant_p4", 64'(gnt[1]), 64'(g_exp));
        if (known) begin
            for (int d = 0; d < 2; d++) begin
                ev = 3'b000;
                if (q[d].size() > 0 && q[d][0].due == cyc) begin
                    ev      = q[d][0].vld;
                    held[d] = q[d][0].prod;
                    q[d].delete(0);
                end
                check_val(d == 0 ? "valid_p2" : "valid_p4", 64'(rv[d]), 64'(ev));
                check_val(d == 0 ? "result_p2" : "result_p4", 64'(ro[d]), 64'(held[d]));
                check_val(d == 0 ? "op0_p2" : "op0_p4", 64'(o0[d]), 64'(eop0));
                check_val(d == 0 ? "op1_p2" : "op1_p4", 64'(o1[d]), 64'(eop1));
            end
        end
        if (!rstn) begin
            m_locked = 1'b0; m_owner = 0; m_last = 2;
            q[0].delete(); q[1].delete();
            held[0] = '0; held[1] = '0;
            eop0 = '0; eop1 = '0;
            known = 1'b1;
        end else begin
            was = m_locked;
            if ((req & g_exp) != 3'b000) begin
                k = g_exp[0] ? 0 : (g_exp[1] ? 1 : 2);
                a = opa[k*W +: W];
                b = opb[k*W +: W];
                p = a * b;
                for (int d = 0; d < 2; d++) q[d].push_back('{cyc + lat[d], 3'(1 << k), p});
                eop0 = a; eop1 = b;
                m_last = k;
                if (!was && lock[k]) begin
                    m_locked = 1'b1;
                    m_owner  = k;
                end
            end
            if (was && !lock[m_owner]) m_locked = 1'b0;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_ops(input int k, input logic [17:0] a, input logic [17:0] b);
        opa[k*W +: W] = a;
        opb[k*W +: W] = b;
    endtask

    initial begin
        cyc = 0; known = 1'b0;
        m_locked = 1'b0; m_owner = 0; m_last = 2;
        held[0] = '0; held[1] = '0; eop0 = '0; eop1 = '0;
        rstn = 1'b0; req = 3'b111; lock = 3'b000; opa = '0; opb = '0;
        repeat (3) run_cycle();
        rstn = 1'b1; req = 3'b000;
        run_cycle();

        // Single signed product 3 * -2
        set_ops(0, 18'h00003, 18'h3FFFE);
        req = 3'b001; run_cycle();
        req = 3'b000; run_cycle();
        #1;
        check_val("t1_result", 64'(bus2.Result_O), 64'(36'hFFFFFFFFA));
        check_val("t1_valid", 64'(bus2.Result_Valid_O), 64'(3'b001));
        run_cycle();
        run_cycle();

        // All three ports requesting, no lock
        opa = 54'({$urandom(), $urandom()}); opb = 54'({$urandom(), $urandom()});
        req = 3'b111;
        repeat (6) run_cycle();
        req = 3'b000; repeat (4) run_cycle();

        // Port 1 locks, goes quiet, then releases while port 0 waits
        req = 3'b010; lock = 3'b010; run_cycle();
        req = 3'b001; repeat (3) run_cycle();
        lock = 3'b000; run_cycle();
        run_cycle();
        req = 3'b000; repeat (4) run_cycle();

        // Ports 2 and 0 alternating back to back
        for (int i = 0; i < 6; i++) begin
            opa = 54'({$urandom(), $urandom()}); opb = 54'({$urandom(), $urandom()});
            req = (i % 2 == 0) ? 3'b100 : 3'b001;
            run_cycle();
        end
        req = 3'b000; repeat (5) run_cycle();

        // Reset one cycle after a transfer
        req = 3'b001; run_cycle();
        req = 3'b000; rstn = 1'b0; run_cycle();
        rstn = 1'b1; repeat (4) run_cycle();

        // Largest positive operands, checked on the 4-stage instance
        set_ops(0, 18'h1FFFF, 18'h1FFFF);
        req = 3'b001; run_cycle();
        req = 3'b000; repeat (3) run_cycle();
        #1;
        check_val("t6_result", 64'(bus4.Result_O), 64'(36'h3FFFC0001));
        check_val("t6_valid", 64'(bus4.Result_Valid_O), 64'(3'b001));
        repeat (3) run_cycle();

        // Random traffic with locks, extreme operands and occasional resets
        for (int i = 0; i < 600; i++) begin
            req  = 3'($urandom_range(0, 7));
            lock = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : (m_locked ? lock : 3'b000);
            case ($urandom_range(0, 3))
                0:       begin opa = {3{18'h20000}}; opb = {3{18'h1FFFF}}; end
                default: begin opa = 54'({$urandom(), $urandom()}); opb = 54'({$urandom(), $urandom()}); end
            endcase
            rstn = ($urandom_range(0, 99) != 0);
            run_cycle();
        end
        rstn = 1'b1; req = 3'b000; lock = 3'b000;
        repeat (6) run_cycle();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
